// File: rtl/aes_key_schedule.sv
// AES-128 round-key producer: expands one cipher key into 11 round keys, one per cycle,
// then streams them forward (encrypt) or reverse (decrypt) over a valid/ready port.
module aes_key_schedule #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [127:0]     i_key_in,
  input  logic             i_decrypt,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [127:0]     o_rk_out,
  output logic [IDX_W-1:0] o_rk_idx,
  output logic             o_rk_valid,
  input  logic             i_rk_ready,
  output logic             o_busy
);

  generate
    if (NR != 10) begin : g_nr_check
      $error("aes_key_schedule: only NR=10 (AES-128) is supported");
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_STREAM} state_t;

  state_t           r_state;
  logic [127:0]     r_buf [0:NR];
  logic [127:0]     r_prev;
  logic [IDX_W-1:0] r_rcnt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_rcon;
  logic             r_dec;
  logic             r_key_ready;
  logic             r_rk_valid;
  logic             r_busy;
  logic [127:0]     w_next;
  logic [IDX_W-1:0] w_last_idx;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign w_next     = next_rk(r_prev, r_rcon);
  assign w_last_idx = r_dec ? '0 : LAST;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_key_ready <= 1'b1;
      r_rk_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_idx       <= '0;
      r_rcnt      <= '0;
      r_rcon      <= 8'h01;
      r_dec       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_key_valid) begin
            r_buf[0]    <= i_key_in;
            r_prev      <= i_key_in;
            r_dec       <= i_decrypt;
            r_rcnt      <= IDX_W'(1);
            r_rcon      <= 8'h01;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          r_buf[r_rcnt] <= w_next;
          r_prev        <= w_next;
          r_rcnt        <= r_rcnt + IDX_W'(1);
          r_rcon        <= xtime(r_rcon);
          // Round 10 lands this edge; first beat is presented right after it
          if (r_rcnt == LAST) begin
            r_state    <= S_STREAM;
            r_rk_valid <= 1'b1;
            r_idx      <= r_dec ? LAST : '0;
          end
        end
        S_STREAM: begin
          if (i_rk_ready) begin
            if (r_idx == w_last_idx) begin
              r_state     <= S_IDLE;
              r_rk_valid  <= 1'b0;
              r_busy      <= 1'b0;
              r_key_ready <= 1'b1;
              r_idx       <= '0;
            end else begin
              r_idx <= r_dec ? r_idx - IDX_W'(1) : r_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_key_ready = r_key_ready;
  assign o_rk_valid  = r_rk_valid;
  assign o_rk_idx    = r_idx;
  assign o_busy      = r_busy;
  assign o_rk_out    = r_rk_valid ? r_buf[r_idx] : '0;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: independent software key expansion plus FIPS-197 anchors.
module tb_aes_key_schedule;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K3     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] rk;
  } beat_t;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [127:0] i_key_in = '0;
  logic         i_decrypt = 1'b0;
  logic         i_key_valid = 1'b0;
  logic         i_rk_ready = 1'b0;
  logic         o_key_ready, o_rk_valid, o_busy;
  logic [127:0] o_rk_out;
  logic [3:0]   o_rk_idx;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    hs_cyc = 0;
  beat_t exp_q[$];

  aes_key_schedule #(.NR(10), .IDX_W(4)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_key_in(i_key_in), .i_decrypt(i_decrypt),
    .i_key_valid(i_key_valid), .o_key_ready(o_key_ready), .o_rk_out(o_rk_out),
    .o_rk_idx(o_rk_idx), .o_rk_valid(o_rk_valid), .i_rk_ready(i_rk_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- reference model: Horner GF multiply, brute-force inverse, bitwise affine ----
  function automatic logic [7:0] tb_gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv = '0;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) if (tb_gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [7:0] tb_rcon(input int r);
    case (r)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;  5: return 8'h10;
      6: return 8'h20;  7: return 8'h40;  8: return 8'h80;  9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [10:0][127:0] model_ks(input logic [127:0] k);
    logic [10:0][127:0] ks;
    logic [31:0] w [0:43];
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0)
        t = {tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0]), tb_sbox(t[31:24])}
            ^ {tb_rcon(i/4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // ---- stimulus helpers (no checking) ----
  task automatic send_key(input logic [127:0] k, input bit d, input bit hold);
    logic [10:0][127:0] ks;
    int n = 0;
    i_key_in = k; i_decrypt = d; i_key_valid = 1'b1;
    while (!o_key_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    hs_cyc = cyc;
    if (!hold) i_key_valid = 1'b0;
    ks = model_ks(k);
    for (int b = 0; b < 11; b++) begin
      int ix = d ? 10 - b : b;
      exp_q.push_back({4'(ix), ks[ix]});
    end
  endtask

  task automatic get_beat(output logic [3:0] idx, output logic [127:0] rk, output int acc,
                          output bit stable, output bit tmo, input int pct);
    logic [3:0]   p_idx = '0;
    logic [127:0] p_rk = '0;
    bit           have = 0;
    stable = 1; tmo = 1; idx = 'x; rk = 'x; acc = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      i_rk_ready = ($urandom_range(99) < pct);
      if (o_rk_valid) begin
        if (have && (o_rk_out !== p_rk || o_rk_idx !== p_idx)) stable = 0;
        p_rk = o_rk_out; p_idx = o_rk_idx; have = 1;
        if (i_rk_ready) begin
          idx = o_rk_idx; rk = o_rk_out;
          @(posedge clk); #1;
          acc = cyc; tmo = 0;
          break;
        end
      end
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); i_rst_n = 1'b1;
    @(negedge clk);
    total++; if (o_key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b exp=1", o_key_ready); end
    total++; if (o_rk_valid !== 1'b0) begin bad++; $display("FAIL reset_rk_valid got=%b exp=0", o_rk_valid); end
    total++; if (o_rk_out !== '0) begin bad++; $display("FAIL reset_rk_out got=%h exp=0", o_rk_out); end
    total++; if (o_rk_idx !== 4'd0) begin bad++; $display("FAIL reset_rk_idx got=%0d exp=0", o_rk_idx); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_forward();
    logic [3:0] idx; logic [127:0] rk; int acc, prev = 0; bit st, to; beat_t e;
    send_key(K1, 1'b0, 1'b0);
    i_key_in = '1;
    @(negedge clk);
    total++;
    if (o_busy !== 1'b1 || o_key_ready !== 1'b0 || o_rk_valid !== 1'b0) begin
      bad++; $display("FAIL fwd_expand_flags busy=%b key_ready=%b rk_valid=%b exp=1/0/0", o_busy, o_key_ready, o_rk_valid);
    end
    for (int b = 0; b < 11; b++) begin
      get_beat(idx, rk, acc, st, to, 100);
      e = exp_q.pop_front();
      total++;
      if (to || idx !== e.idx || rk !== e.rk || !st) begin
        bad++; $display("FAIL fwd_beat%0d got idx=%0d rk=%h exp idx=%0d rk=%h to=%b", b, idx, rk, e.idx, e.rk, to);
      end
      total++;
      if (b == 0 ? (acc - hs_cyc != 11) : (acc - prev != 1)) begin
        bad++; $display("FAIL fwd_timing beat%0d got gap=%0d exp=%0d", b, b == 0 ? acc - hs_cyc : acc - prev, b == 0 ? 11 : 1);
      end
      prev = acc;
      if (b == 0) begin total++; if (rk !== K1) begin bad++; $display("FAIL fwd_rk0 got=%h exp=%h", rk, K1); end end
      if (b == 1) begin total++; if (rk !== K1_R1) begin bad++; $display("FAIL fwd_rk1 got=%h exp=%h", rk, K1_R1); end end
      if (b == 10) begin total++; if (rk !== K1_R10) begin bad++; $display("FAIL fwd_rk10 got=%h exp=%h", rk, K1_R10); end end
    end
    @(negedge clk);
    total++;
    if (o_rk_valid !== 1'b0 || o_key_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL fwd_end_flags rk_valid=%b key_ready=%b busy=%b exp=0/1/0", o_rk_valid, o_key_ready, o_busy);
    end
  endtask

  task automatic test_reverse();
    logic [3:0] idx; logic [127:0] rk; int acc; bit st, to; beat_t e;
    send_key(K1, 1'b1, 1'b0);
    for (int b = 0; b < 11; b++) begin
      get_beat(idx, rk, acc, st, to, 100);
      e = exp_q.pop_front();
      total++;
      if (to || idx !== e.idx || rk !== e.rk) begin
        bad++; $display("FAIL rev_beat%0d got idx=%0d rk=%h exp idx=%0d rk=%h", b, idx, rk, e.idx, e.rk);
      end
      if (b == 0) begin total++; if (idx !== 4'd10 || rk !== K1_R10) begin bad++; $display("FAIL rev_first got idx=%0d rk=%h exp idx=10 rk=%h", idx, rk, K1_R10); end end
      if (b == 10) begin total++; if (idx !== 4'd0 || rk !== K1) begin bad++; $display("FAIL rev_last got idx=%0d rk=%h exp idx=0 rk=%h", idx, rk, K1); end end
    end
  endtask

  task automatic test_key2();
    logic [3:0] idx; logic [127:0] rk; int acc; bit st, to; beat_t e;
    send_key(K3, 1'b0, 1'b0);
    for (int b = 0; b < 11; b++) begin
      get_beat(idx, rk, acc, st, to, 100);
      e = exp_q.pop_front();
      total++;
      if (to || idx !== e.idx || rk !== e.rk) begin
        bad++; $display("FAIL key2_beat%0d got idx=%0d rk=%h exp idx=%0d rk=%h", b, idx, rk, e.idx, e.rk);
      end
      if (b == 10) begin total++; if (rk !== K3_R10) begin bad++; $display("FAIL key2_rk10 got=%h exp=%h", rk, K3_R10); end end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] idx; logic [127:0] rk; int acc; bit st, to; beat_t e;
    send_key(K1, 1'b0, 1'b0);
    for (int b = 0; b < 11; b++) begin
      get_beat(idx, rk, acc, st, to, 50);
      e = exp_q.pop_front();
      total++;
      if (to || idx !== e.idx || rk !== e.rk || !st) begin
        bad++; $display("FAIL bp_beat%0d got idx=%0d rk=%h stable=%b exp idx=%0d rk=%h stable=1", b, idx, rk, st, e.idx, e.rk);
      end
    end
    i_rk_ready = 1'b1;
    @(negedge clk);
    total++; if (o_rk_valid !== 1'b0 || o_key_ready !== 1'b1) begin bad++; $display("FAIL bp_count extra beat rk_valid=%b key_ready=%b", o_rk_valid, o_key_ready); end
  endtask

  task automatic test_key_valid_ignored();
    logic [3:0] idx; logic [127:0] rk; int acc; bit st, to; beat_t e;
    send_key(K1, 1'b0, 1'b1);
    i_key_in = K3;
    for (int b = 0; b < 11; b++) begin
      get_beat(idx, rk, acc, st, to, 100);
      e = exp_q.pop_front();
      total++;
      if (to || idx !== e.idx || rk !== e.rk) begin
        bad++; $display("FAIL ign_beat%0d got idx=%0d rk=%h exp idx=%0d rk=%h", b, idx, rk, e.idx, e.rk);
      end
    end
    send_key(K3, 1'b0, 1'b0);
    total++; if (hs_cyc - acc != 1) begin bad++; $display("FAIL ign_second_hs got gap=%0d exp=1", hs_cyc - acc); end
    for (int b = 0; b < 11; b++) begin
      get_beat(idx, rk, acc, st, to, 100);
      e = exp_q.pop_front();
      total++;
      if (to || idx !== e.idx || rk !== e.rk) begin
        bad++; $display("FAIL ign2_beat%0d got idx=%0d rk=%h exp idx=%0d rk=%h", b, idx, rk, e.idx, e.rk);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [3:0] idx; logic [127:0] rk; int acc; bit st, to; beat_t e;
    send_key(K3, 1'b1, 1'b0);
    for (int b = 0; b < 5; b++) begin
      get_beat(idx, rk, acc, st, to, 100);
      e = exp_q.pop_front();
      total++;
      if (to || idx !== e.idx || rk !== e.rk) begin
        bad++; $display("FAIL rst_beat%0d got idx=%0d rk=%h exp idx=%0d rk=%h", b, idx, rk, e.idx, e.rk);
      end
    end
    @(negedge clk);
    total++; if (o_rk_valid !== 1'b1 || o_rk_idx !== 4'd5) begin bad++; $display("FAIL rst_beat5_present rk_valid=%b idx=%0d exp 1/5", o_rk_valid, o_rk_idx); end
    i_rst_n = 1'b0;
    @(negedge clk);
    total++; if (o_rk_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL rst_abort rk_valid=%b busy=%b exp 0/0", o_rk_valid, o_busy); end
    i_rst_n = 1'b1;
    @(negedge clk);
    total++; if (o_key_ready !== 1'b1 || o_rk_valid !== 1'b0) begin bad++; $display("FAIL rst_release key_ready=%b rk_valid=%b exp 1/0", o_key_ready, o_rk_valid); end
    exp_q.delete();
    send_key(K1, 1'b1, 1'b0);
    for (int b = 0; b < 11; b++) begin
      get_beat(idx, rk, acc, st, to, 100);
      e = exp_q.pop_front();
      total++;
      if (to || idx !== e.idx || rk !== e.rk) begin
        bad++; $display("FAIL rst_new_beat%0d got idx=%0d rk=%h exp idx=%0d rk=%h", b, idx, rk, e.idx, e.rk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_key2();
    test_backpressure();
    test_key_valid_ignored();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
